// File: rtl/seq_adder_n_if.sv
// Start/busy/done handshake and operand/result bus for seq_adder_n.
// The requester drives the master side; the adder implements the slave side.
interface seq_adder_n_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, a, b, cin, sub,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, a, b, cin, sub,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/seq_adder_n.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, LSB chunk first,
// with a start/busy/done handshake. WIDTH >= 2 and WIDTH % CHUNK == 0 are required.
module seq_adder_n #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 1
) (
   input  logic         clk,
   input  logic         rst,
   seq_adder_n_if.slave bus
);
   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry;
   logic [WIDTH-1:0] part;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;
   logic             done_q;

   int               base;
   logic [CHUNK-1:0] a_ch;
   logic [CHUNK-1:0] b_ch;
   logic [CHUNK:0]   chunk_sum;
   logic [WIDTH-1:0] part_next;
   logic             last;

   always_comb begin
      // NOTE: every output of this block is assigned unconditionally first,
      // so no path can leave one holding its old value and infer a latch.
      base      = int'(cnt) * CHUNK;
      a_ch      = a_q[base +: CHUNK];
      b_ch      = b_q[base +: CHUNK];
      chunk_sum = {1'b0, a_ch} + {1'b0, b_ch} + (CHUNK + 1)'(carry);
      part_next = part;
      part_next[base +: CHUNK] = chunk_sum[CHUNK-1:0];
      last      = (cnt == CW'(N - 1));
   end

   // b is stored already inverted for subtract, and the borrow-in becomes
   // an inverted carry-in, so RUN only ever performs an addition.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values regardless of statement order.
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         carry  <= 1'b0;
         part   <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_q   <= bus.a;
                  b_q   <= bus.sub ? ~bus.b : bus.b;
                  carry <= bus.cin ^ bus.sub;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               part  <= part_next;
               carry <= chunk_sum[CHUNK];
               cnt   <= cnt + CW'(1);
               if (last) begin
                  state  <= IDLE;
                  sum_q  <= part_next;
                  cout_q <= chunk_sum[CHUNK];
                  ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                            (part_next[WIDTH-1] != a_q[WIDTH-1]);
                  done_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = (state == RUN);
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_seq_adder_n.sv
// Drives four WIDTH=8 adders (CHUNK 1, 2, 4, 8) with shared stimulus and
// compares every output, every cycle, against a cycle-level arithmetic model.
module tb_seq_adder_n;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       cin = 1'b0;
   logic       sub = 1'b0;

   logic [3:0] busy_o, done_o, cout_o, ovf_o;
   logic [7:0] sum_o [4];

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      seq_adder_n_if #(.WIDTH(8)) bus ();
      assign bus.start = start;
      assign bus.a     = a;
      assign bus.b     = b;
      assign bus.cin   = cin;
      assign bus.sub   = sub;
      assign busy_o[g] = bus.busy;
      assign done_o[g] = bus.done;
      assign cout_o[g] = bus.cout;
      assign ovf_o[g]  = bus.ovf;
      assign sum_o[g]  = bus.sum;
      seq_adder_n #(.WIDTH(8), .CHUNK(1 << g)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
   end

   // Reference state per instance: cycles left, pending and visible results.
   int         nchunks [4] = '{8, 4, 2, 1};
   int         rem     [4];
   logic [9:0] pend    [4];
   logic       m_busy  [4];
   logic       m_done  [4];
   logic [9:0] m_res   [4];

   // {ovf, cout, sum} from plain integer arithmetic on the operands.
   function automatic logic [9:0] ref_op(logic [7:0] x, logic [7:0] y, logic ci, logic s);
      int ux, uy, sx, sy, c, r, sr;
      ux = int'(x);
      uy = int'(y);
      c  = int'(ci);
      sx = x[7] ? ux - 256 : ux;
      sy = y[7] ? uy - 256 : uy;
      if (s) begin
         r  = ux - uy - c;
         sr = sx - sy - c;
      end else begin
         r  = ux + uy + c;
         sr = sx + sy + c;
      end
      return {(sr > 127) || (sr < -128), s ? (r >= 0) : (r > 255), 8'(r)};
   endfunction

   task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         m_done[k] = 1'b0;
         if (rst) begin
            rem[k]    = 0;
            m_busy[k] = 1'b0;
            m_res[k]  = '0;
         end else if (rem[k] == 0) begin
            if (start) begin
               rem[k]    = nchunks[k];
               pend[k]   = ref_op(a, b, cin, sub);
               m_busy[k] = 1'b1;
            end
         end else begin
            rem[k]--;
            if (rem[k] == 0) begin
               m_busy[k] = 1'b0;
               m_done[k] = 1'b1;
               m_res[k]  = pend[k];
            end
         end
      end
      #1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("c%0d_busy", nchunks[k]), 8'(busy_o[k]), 8'(m_busy[k]));
         check($sformatf("c%0d_done", nchunks[k]), 8'(done_o[k]), 8'(m_done[k]));
         check($sformatf("c%0d_sum", nchunks[k]),  sum_o[k],      m_res[k][7:0]);
         check($sformatf("c%0d_cout", nchunks[k]), 8'(cout_o[k]), 8'(m_res[k][8]));
         check($sformatf("c%0d_ovf", nchunks[k]),  8'(ovf_o[k]),  8'(m_res[k][9]));
      end
   endtask

   task automatic drive(logic s_start, logic [7:0] x, logic [7:0] y, logic ci, logic s);
      start = s_start;
      a     = x;
      b     = y;
      cin   = ci;
      sub   = s;
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic       sub;
   } op_t;

   op_t dir [7];

   initial begin
      for (int k = 0; k < 4; k++) begin
         rem[k] = 0; pend[k] = '0; m_busy[k] = 1'b0; m_done[k] = 1'b0; m_res[k] = '0;
      end
      dir = '{'{8'h01, 8'h01, 1'b0, 1'b0}, '{8'hFF, 8'h01, 1'b0, 1'b0},
              '{8'h7F, 8'h7F, 1'b0, 1'b0}, '{8'hFF, 8'hFF, 1'b1, 1'b0},
              '{8'h0F, 8'h0F, 1'b1, 1'b0}, '{8'h05, 8'h07, 1'b0, 1'b1},
              '{8'h80, 8'h01, 1'b0, 1'b1}};

      // Reset state.
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;

      // Directed vectors; operands are scrambled while the adders run.
      foreach (dir[i]) begin
         drive(1'b1, dir[i].a, dir[i].b, dir[i].cin, dir[i].sub);
         step();
         for (int c = 0; c < 9; c++) begin
            drive(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            step();
         end
      end

      // Second start at cycle 3 is ignored by instances still running.
      drive(1'b1, 8'h03, 8'h01, 1'b0, 1'b0);
      step();
      drive(1'b0, 8'h03, 8'h01, 1'b0, 1'b0);
      step();
      step();
      drive(1'b1, 8'h55, 8'h22, 1'b1, 1'b1);
      step();
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      for (int c = 0; c < 9; c++) step();

      // Start held high: each instance re-accepts on its done cycle.
      for (int c = 0; c < 20; c++) begin
         drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
         step();
      end
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      for (int c = 0; c < 9; c++) step();

      // Reset mid-operation, with start asserted alongside reset.
      drive(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
      step();
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      step();
      step();
      step();
      rst = 1'b1;
      drive(1'b1, 8'h66, 8'h11, 1'b0, 1'b0);
      step();
      rst = 1'b0;
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      step();
      step();
      drive(1'b1, 8'h21, 8'h43, 1'b1, 1'b0);
      step();
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      for (int c = 0; c < 9; c++) step();

      // Random traffic with occasional resets.
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 59) == 0);
         drive(($urandom_range(0, 2) == 0), 8'($urandom), 8'($urandom),
               1'($urandom), 1'($urandom));
         step();
      end
      rst = 1'b0;
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      for (int c = 0; c < 9; c++) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
